// File: rtl/ntt_output_collector_if.sv
// Beat-in / coefficient-out bus of the NTT output collector.
// The slave modport is the collector side; the master modport is the router/consumer side.
interface ntt_output_collector_if #(
  parameter int LOG_CORE_COUNT = 5
);
  localparam int C = 1 << LOG_CORE_COUNT;

  logic [C-1:0][1:0][59:0]   out_in;
  logic [8:0]                address_in;
  logic                      in_valid;
  logic                      in_last;
  logic                      in_ready;

  logic [29:0]               m_data;
  logic [8:0]                m_addr;
  logic [LOG_CORE_COUNT-1:0] m_core;
  logic [1:0]                m_slot;
  logic                      m_last;
  logic                      m_valid;
  logic                      m_ready;

  modport slave (
    input  out_in, address_in, in_valid, in_last, m_ready,
    output in_ready, m_data, m_addr, m_core, m_slot, m_last, m_valid
  );

  modport master (
    output out_in, address_in, in_valid, in_last, m_ready,
    input  in_ready, m_data, m_addr, m_core, m_slot, m_last, m_valid
  );
endinterface

// File: rtl/ntt_output_collector.sv
// Two-entry ping-pong buffer that takes whole router beats (4*C coefficients) and
// serializes them one 30-bit coefficient per transfer, core-major then slot.
module ntt_output_collector #(
  parameter int LOG_CORE_COUNT = 5
) (
  input logic                    clk,
  input logic                    rst_n,
  ntt_output_collector_if.slave  bus
);
  localparam int C     = 1 << LOG_CORE_COUNT;
  localparam int B     = 4 * C;
  localparam int CNT_W = LOG_CORE_COUNT + 2;

  typedef logic [C-1:0][1:0][59:0] beat_t;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e             occ_q, occ_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  beat_t            data_q [2];
  logic [8:0]       addr_q [2];
  logic             last_q [2];

  logic             has_data;
  logic             accept;
  logic             xfer;
  logic             final_pop;
  logic [59:0]      word;
  logic [29:0]      coef;

  // in_ready depends on registered occupancy only, so m_ready never reaches it.
  assign has_data  = (occ_q != EMPTY);
  assign accept    = bus.in_valid && (occ_q != FULL);
  assign xfer      = has_data && bus.m_ready;
  assign final_pop = xfer && (cnt_q == CNT_W'(B - 1));

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (accept)    wr_ptr_d = ~wr_ptr_q;
    if (xfer)      cnt_d    = cnt_q + CNT_W'(1);
    if (final_pop) rd_ptr_d = ~rd_ptr_q;

    case ({accept, final_pop})
      2'b10:   occ_d = (occ_q == EMPTY) ? ONE : FULL;
      2'b01:   occ_d = (occ_q == FULL) ? ONE : EMPTY;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      occ_q    <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: payload storage is deliberately not reset; outputs are gated by occupancy so stale words never show.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q[wr_ptr_q] <= bus.out_in;
      addr_q[wr_ptr_q] <= bus.address_in;
      last_q[wr_ptr_q] <= bus.in_last;
    end
  end

  assign word = data_q[rd_ptr_q][cnt_q[CNT_W-1:2]][cnt_q[1]];
  assign coef = cnt_q[0] ? word[59:30] : word[29:0];

  assign bus.in_ready = (occ_q != FULL);
  assign bus.m_valid  = has_data;
  assign bus.m_data   = has_data ? coef : '0;
  assign bus.m_addr   = has_data ? addr_q[rd_ptr_q] : '0;
  assign bus.m_core   = cnt_q[CNT_W-1:2];
  assign bus.m_slot   = cnt_q[1:0];
  assign bus.m_last   = has_data && last_q[rd_ptr_q] && (cnt_q == CNT_W'(B - 1));

endmodule

// File: tb/tb_ntt_output_collector.sv
// Bench for ntt_output_collector (C = 2, B = 8): directed scenarios plus random traffic,
// checked every cycle against a queue-of-beats model.
module tb_ntt_output_collector;
  localparam int L = 1;
  localparam int C = 1 << L;
  localparam int B = 4 * C;

  typedef logic [C-1:0][1:0][59:0] beat_data_t;
  typedef struct {
    beat_data_t d;
    logic [8:0] a;
    logic       l;
  } beat_t;
  typedef struct {
    logic [29:0]  data;
    logic [L-1:0] core;
    logic [1:0]   slot;
    logic [8:0]   addr;
    logic         last;
    int           cyc;
  } xfer_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ntt_output_collector_if #(.LOG_CORE_COUNT(L)) bus_if ();

  ntt_output_collector #(.LOG_CORE_COUNT(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int    checks = 0;
  int    errors = 0;
  beat_t model_q[$];
  int    model_idx = 0;
  int    model_n;
  xfer_t log_q[$];
  int    cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Coefficient i of a beat is simply the i-th 30-bit field of the flattened beat.
  function automatic logic [29:0] model_coef(input beat_data_t d, input int i);
    logic [C*120-1:0] flat;
    flat = d;
    return flat[30*i +: 30];
  endfunction

  function automatic beat_data_t seq_beat(input int base);
    beat_data_t d;
    for (int k = 0; k < C; k++)
      for (int p = 0; p < 2; p++)
        d[k][p] = {30'(base + 4*k + 2*p + 2), 30'(base + 4*k + 2*p + 1)};
    return d;
  endfunction

  function automatic beat_data_t rand_beat();
    beat_data_t d;
    for (int k = 0; k < C; k++)
      for (int p = 0; p < 2; p++)
        d[k][p] = 60'({$urandom(), $urandom()});
    return d;
  endfunction

  // Model: beats queue up (at most two); the head beat is emitted one coefficient per transfer.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      model_q.delete();
      model_idx = 0;
    end else begin
      cyc++;
      model_n = model_q.size();
      if (bus_if.m_valid && bus_if.m_ready)
        log_q.push_back('{bus_if.m_data, bus_if.m_core, bus_if.m_slot,
                          bus_if.m_addr, bus_if.m_last, cyc});
      if (bus_if.m_ready && model_n > 0) begin
        model_idx++;
        if (model_idx == B) begin
          model_q.delete(0);
          model_idx = 0;
        end
      end
      if (bus_if.in_valid && model_n < 2)
        model_q.push_back('{bus_if.out_in, bus_if.address_in, bus_if.in_last});
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("in_ready", bus_if.in_ready, model_q.size() < 2);
      check("m_valid", bus_if.m_valid, model_q.size() > 0);
      if (model_q.size() > 0) begin
        check("m_data", bus_if.m_data, model_coef(model_q[0].d, model_idx));
        check("m_addr", bus_if.m_addr, model_q[0].a);
        check("m_core", bus_if.m_core, model_idx / 4);
        check("m_slot", bus_if.m_slot, model_idx % 4);
        check("m_last", bus_if.m_last, model_q[0].l && model_idx == B - 1);
      end
    end
  end

  task automatic drive_beat(input beat_data_t d, input logic [8:0] a, input logic l);
    bus_if.out_in     = d;
    bus_if.address_in = a;
    bus_if.in_last    = l;
    bus_if.in_valid   = 1'b1;
  endtask

  task automatic send_beat(input beat_data_t d, input logic [8:0] a, input logic l);
    bit done = 0;
    int k = 0;
    drive_beat(d, a, l);
    while (!done && k < 100) begin
      @(negedge clk);
      if (bus_if.in_ready) done = 1;
      @(posedge clk);
      #1;
      k++;
    end
    bus_if.in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic wait_log(input int n);
    int k = 0;
    while (log_q.size() < n && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_count", log_q.size(), n);
  endtask

  initial begin
    int lows;
    bus_if.out_in     = '0;
    bus_if.address_in = '0;
    bus_if.in_valid   = 1'b0;
    bus_if.in_last    = 1'b0;
    bus_if.m_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", bus_if.in_ready, 1);
    check("rst_m_valid", bus_if.m_valid, 0);
    check("rst_m_data", bus_if.m_data, 0);

    // Single beat, free-flowing consumer.
    log_q.delete();
    bus_if.m_ready = 1'b1;
    send_beat(seq_beat(0), 9'd5, 1'b0);
    wait_log(8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      check("t1_data", log_q[i].data, i + 1);
      check("t1_core", log_q[i].core, i / 4);
      check("t1_slot", log_q[i].slot, i % 4);
      check("t1_addr", log_q[i].addr, 5);
      check("t1_last", log_q[i].last, 0);
      if (i > 0) check("t1_gapless", log_q[i].cyc - log_q[i-1].cyc, 1);
    end

    // Backpressure on the third coefficient.
    log_q.delete();
    bus_if.m_ready = 1'b0;
    send_beat(seq_beat(0), 9'd7, 1'b0);
    bus_if.m_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_if.m_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_data", bus_if.m_data, 3);
      check("bp_hold_slot", bus_if.m_slot, 2);
      @(posedge clk); #1;
    end
    bus_if.m_ready = 1'b1;
    wait_log(8);
    for (int i = 0; i < 8 && i < log_q.size(); i++)
      check("bp_data", log_q[i].data, i + 1);

    // Fill both entries with the consumer stalled.
    log_q.delete();
    bus_if.m_ready = 1'b0;
    drive_beat(rand_beat(), 9'd1, 1'b0);
    @(negedge clk); check("fill_rdy0", bus_if.in_ready, 1);
    @(posedge clk); #1;
    drive_beat(rand_beat(), 9'd2, 1'b0);
    @(negedge clk); check("fill_rdy1", bus_if.in_ready, 1);
    @(posedge clk); #1;
    drive_beat(rand_beat(), 9'd3, 1'b0);
    @(negedge clk); check("fill_rdy2", bus_if.in_ready, 0);
    @(posedge clk); #1;
    bus_if.m_ready = 1'b1;
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_if.in_ready) break;
      lows++;
      @(posedge clk); #1;
    end
    check("fill_wait_cycles", lows, 8);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    wait_log(24);
    for (int i = 0; i < 24 && i < log_q.size(); i++)
      check("fill_order_addr", log_q[i].addr, i / 8 + 1);
    if (log_q.size() == 24) check("fill_gapless", log_q[23].cyc - log_q[0].cyc, 23);

    // Back-to-back beats, second one closes the polynomial.
    log_q.delete();
    send_beat(rand_beat(), 9'd10, 1'b0);
    send_beat(rand_beat(), 9'd11, 1'b1);
    wait_log(16);
    if (log_q.size() == 16) check("b2b_gapless", log_q[15].cyc - log_q[0].cyc, 15);
    for (int i = 0; i < 16 && i < log_q.size(); i++)
      check("b2b_last", log_q[i].last, i == 15);

    // Asynchronous reset in the middle of a beat.
    send_beat(seq_beat(0), 9'd12, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", bus_if.m_valid, 0);
    check("arst_in_ready", bus_if.in_ready, 1);
    check("arst_m_data", bus_if.m_data, 0);
    check("arst_m_addr", bus_if.m_addr, 0);
    check("arst_m_core", bus_if.m_core, 0);
    check("arst_m_slot", bus_if.m_slot, 0);
    check("arst_m_last", bus_if.m_last, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    log_q.delete();
    send_beat(seq_beat(100), 9'd13, 1'b0);
    wait_log(8);
    if (log_q.size() > 0) begin
      check("arst_first_core", log_q[0].core, 0);
      check("arst_first_slot", log_q[0].slot, 0);
      check("arst_first_data", log_q[0].data, 101);
      check("arst_first_addr", log_q[0].addr, 13);
    end

    // Random traffic; payload also changes while in_ready is low.
    for (int n = 0; n < 3000; n++) begin
      bus_if.in_valid   = 1'($urandom_range(0, 1));
      bus_if.out_in     = rand_beat();
      bus_if.address_in = 9'($urandom());
      bus_if.in_last    = 1'($urandom_range(0, 1));
      bus_if.m_ready    = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus_if.in_valid = 1'b0;
    bus_if.m_ready  = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("final_empty", bus_if.m_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
